// File: rtl/sr_ff_pkg.sv
// sr_ff_pkg: shared command encoding and reset constant for the SR flip-flop bank.
package sr_ff_pkg;

    // Command seen by one bit, encoded as {S,R}
    typedef enum logic [1:0] {
        SR_HOLD    = 2'b00,
        SR_RESET   = 2'b01,
        SR_SET     = 2'b10,
        SR_INVALID = 2'b11
    } sr_cmd_t;

    // Value every stored bit takes on reset
    localparam logic SR_Q_RST = 1'b0;

    // Pack one bit's set/reset request pair into a command
    function automatic sr_cmd_t sr_cmd(input logic s, input logic r);
        return sr_cmd_t'({s, r});
    endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// sr_ff_cell: single-bit synchronous SR register.
// S=R=1 holds the stored value, so the output is always defined.
module sr_ff_cell
    import sr_ff_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q
);

    // Reset first, then set/clear/hold; the forbidden pair falls through to hold
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SR_Q_RST;
        end else begin
            case (sr_cmd(s, r))
                SR_SET:   q <= 1'b1;
                SR_RESET: q <= 1'b0;
                default:  q <= q;
            endcase
        end
    end

endmodule

// File: rtl/sr_ff.sv
// sr_ff: bank of WIDTH independent clocked SR flip-flops.
// Optional feature macro: SR_FF_INVALID_FLAG_EN adds a sticky 'invalid'
// output that records any bit sampling S=R=1 since the last reset.
module sr_ff
    import sr_ff_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
`ifdef SR_FF_INVALID_FLAG_EN
    ,
    output logic             invalid
`endif
);

    // One storage cell per bit; bits never interact
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_ff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .s   (S[i]),
            .r   (R[i]),
            .q   (Q[i])
        );
    end

    // Complement derived from the register so Q and Qn can never disagree
    assign Qn = ~Q;

`ifdef SR_FF_INVALID_FLAG_EN
    logic [WIDTH-1:0] bad_bit;

    // Per-bit detect of the forbidden request pair
    always_comb begin
        bad_bit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bad_bit[i] = (sr_cmd(S[i], R[i]) == SR_INVALID);
        end
    end

    // Sticky flag: set by any forbidden pair, cleared only by reset (reset wins)
    always_ff @(posedge clk) begin
        if (rst) begin
            invalid <= 1'b0;
        end else if (|bad_bit) begin
            invalid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sr_ff.sv
// tb_sr_ff: directed-vector bench for sr_ff, WIDTH=1 and WIDTH=4 instances.
// Flag checks are compiled in when SR_FF_INVALID_FLAG_EN is defined.
`timescale 1ns/1ps
module tb_sr_ff;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s1 = 1'b0, r1 = 1'b0;
    logic [3:0] s4 = 4'h0, r4 = 4'h0;
    logic       q1, qn1;
    logic [3:0] q4, qn4;
`ifdef SR_FF_INVALID_FLAG_EN
    logic       inv1, inv4;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sr_ff #(.WIDTH(1)) dut1 (
        .clk (clk), .rst (rst), .S (s1), .R (r1), .Q (q1), .Qn (qn1)
`ifdef SR_FF_INVALID_FLAG_EN
        , .invalid (inv1)
`endif
    );

    sr_ff #(.WIDTH(4)) dut4 (
        .clk (clk), .rst (rst), .S (s4), .R (r4), .Q (q4), .Qn (qn4)
`ifdef SR_FF_INVALID_FLAG_EN
        , .invalid (inv4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, pass one rising edge, settle 1 ns
    task automatic step(input logic rv, input logic sv, input logic rrv,
                        input logic [3:0] s4v, input logic [3:0] r4v);
        @(negedge clk);
        rst = rv; s1 = sv; r1 = rrv; s4 = s4v; r4 = r4v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1. reset with S=1 asserted
        step(1'b1, 1'b1, 1'b0, 4'hF, 4'h0);
        chk("rst_q", q1, 1'b0);
        chk("rst_qn", qn1, 1'b1);
        chk("rst_q4", q4, 4'h0);
        chk("rst_qn4", qn4, 4'hF);
`ifdef SR_FF_INVALID_FLAG_EN
        chk("rst_inv", inv1, 1'b0);
`endif

        // 2. basic sequence 00,10,01,00 -> 0,1,0,0
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        chk("seq00_q", q1, 1'b0);  chk("seq00_qn", qn1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        chk("seq10_q", q1, 1'b1);  chk("seq10_qn", qn1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        chk("seq01_q", q1, 1'b0);  chk("seq01_qn", qn1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        chk("seq00b_q", q1, 1'b0); chk("seq00b_qn", qn1, 1'b1);
`ifdef SR_FF_INVALID_FLAG_EN
        chk("seq_inv", inv1, 1'b0);
`endif

        // S pulse between edges must not reach Q
        @(negedge clk);
        s1 = 1'b1;
        #2;
        s1 = 1'b0;
        @(posedge clk);
        #1;
        chk("glitch_q", q1, 1'b0);

        // 3. hold after set for 3 edges
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        chk("set_q", q1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
            chk("hold_q", q1, 1'b1);
            chk("hold_qn", qn1, 1'b0);
        end

        // 4. forbidden input with Q=1 for 2 edges, then clear
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
            chk("forb_q", q1, 1'b1);
`ifdef SR_FF_INVALID_FLAG_EN
            chk("forb_inv", inv1, 1'b1);
`endif
        end
        step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        chk("forb_clr_q", q1, 1'b0);
`ifdef SR_FF_INVALID_FLAG_EN
        chk("forb_sticky", inv1, 1'b1);
`endif

        // 5. reset priority
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        chk("pri_set_q", q1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
        chk("pri_rst_q", q1, 1'b0);
`ifdef SR_FF_INVALID_FLAG_EN
        chk("pri_rst_inv", inv1, 1'b0);
`endif
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        chk("pri_resume_q", q1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 4'h0, 4'h0);
        chk("pri_rst11_q", q1, 1'b0);
`ifdef SR_FF_INVALID_FLAG_EN
        chk("pri_rst11_inv", inv1, 1'b0);
`endif
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        chk("pri_after_q", q1, 1'b0);
`ifdef SR_FF_INVALID_FLAG_EN
        chk("pri_after_inv", inv1, 1'b0);
`endif
        step(1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
        chk("forb_q0_q", q1, 1'b0);
`ifdef SR_FF_INVALID_FLAG_EN
        chk("forb_q0_inv", inv1, 1'b1);
`endif

        // 6. WIDTH=4 independent bits, starting from a clean reset
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        chk("w4_rst_q", q4, 4'h0);
        step(1'b0, 1'b0, 1'b0, 4'b1010, 4'b0101);
        chk("w4_a_q", q4, 4'b1010);
        chk("w4_a_qn", qn4, 4'b0101);
        step(1'b0, 1'b0, 1'b0, 4'b0001, 4'b1000);
        chk("w4_b_q", q4, 4'b0011);
        chk("w4_b_qn", qn4, 4'b1100);
`ifdef SR_FF_INVALID_FLAG_EN
        chk("w4_b_inv", inv4, 1'b0);
`endif
        // mixed: bit3 set, bit2 forbidden (holds 0), bit1 forbidden (holds 1), bit0 reset
        step(1'b0, 1'b0, 1'b0, 4'b1110, 4'b0111);
        chk("w4_c_q", q4, 4'b1010);
`ifdef SR_FF_INVALID_FLAG_EN
        chk("w4_c_inv", inv4, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sr_ff.md
# sr_ff

Clocked set/reset flip-flop bank: each bit stores state that is set by `S`, cleared by `R`, and held when neither is asserted. Every bit updates on the rising clock edge. The block is the basic storage primitive of the flip-flop library and sits beside the D/JK/T variants. `S=R=1` has a defined, deterministic meaning, and the block can optionally flag it.

## Interface
Parameters:
- `WIDTH`, default 1: number of independent SR bits.

Ports:
- `clk`: input, 1 bit. Single clock; all state changes on its rising edge.
- `rst`: input, 1 bit. Reset is synchronous and active-high.
- `S`: input, WIDTH bits. Per-bit set request.
- `R`: input, WIDTH bits. Per-bit reset request.
- `Q`: output, WIDTH bits. Stored state, registered.
- `Qn`: output, WIDTH bits. Always `~Q`.
- `invalid`: output, 1 bit. Present only with `SR_FF_INVALID_FLAG_EN`. Sticky flag that at least one bit saw `S=R=1`.

## Operation
Per bit `i`, evaluated at each rising `clk`:
- `rst=1`:
  - `Q[i] <= 0`.
  - `invalid <= 0`.
  - Reset overrides `S` and `R`.
- `S=0, R=0`: hold `Q[i]`.
- `S=1, R=0`: `Q[i] <= 1`.
- `S=0, R=1`: `Q[i] <= 0`.
- `S=1, R=1`: the forbidden input.
  - `Q[i]` holds its previous value.
  - The output never goes X or oscillates.
- Bits are fully independent. No cross-bit interaction.
- `Qn` is combinational from the `Q` register, never separately stored, so `Q` and `Qn` are always complementary.
- No asynchronous paths. Changes on `S` or `R` between edges have no effect on `Q`.

## Timing
- Latency: one cycle. Inputs sampled at edge N appear on `Q` immediately after edge N.
- Power-up before the first reset is undefined in RTL. Verification always applies `rst` first.
- Reset values: `Q=0`, `Qn=all ones`, `invalid=0`.
- Reset in the middle of a set/reset sequence clears `Q` on that edge. Normal operation resumes on the next edge with `rst=0`.
- `invalid`:
  - Rises on the edge at which any bit samples `S=R=1`.
  - Stays high until `rst`.
  - If `rst` and `S=R=1` occur on the same edge, reset wins and `invalid=0`.

## Configuration
- Macro: `SR_FF_INVALID_FLAG_EN`.
- Defined: the `invalid` port and its sticky register are compiled in, following the Timing rules.
- Undefined: the port and register are absent. `S=R=1` still holds `Q`. The datapath is otherwise identical.

## Structure
- Package `sr_ff_pkg` holds:
  - the 2-bit command encoding `{S,R}`: `SR_HOLD=2'b00`, `SR_RESET=2'b01`, `SR_SET=2'b10`, `SR_INVALID=2'b11`;
  - the reset constant `SR_Q_RST=1'b0`.
- Sub-module `sr_ff_cell`: a single-bit SR register with `clk`, `rst`, `s`, `r`, `q`.
  - The top instantiates WIDTH cells via generate.
  - The top ORs the per-bit invalid detects into the sticky flag.

## Test plan
Clock period 10 ns. Inputs change away from rising edges. `WIDTH=1` unless noted.

1. Reset: `rst=1` for one edge with `S=1` → `Q=0`, `Qn=1`, `invalid=0`.
2. Basic sequence `S/R` = 00, 10, 01, 00, one edge each → `Q` = 0, 1, 0, 0. `Qn` is always the complement.
3. Hold after set: `S=1` for one edge, then `S=R=0` for 3 edges → `Q` stays 1 for all 3 edges.
4. Forbidden input:
   - With `Q=1`, apply `S=R=1` for 2 edges → `Q` stays 1 and `invalid=1`.
   - Then `S=0, R=1` → `Q=0` while `invalid` stays 1 until `rst`.
5. Reset priority:
   - With `Q=1`, apply `rst=1, S=1, R=0` → `Q=0`.
   - Apply `rst=1, S=R=1` → `invalid=0`.
6. `WIDTH=4`, from `Q=4'b0000`: apply `S=4'b1010, R=4'b0101` → `Q=4'b1010`. Then `S=4'b0001, R=4'b1000` → `Q=4'b0011`.
